// File: rtl/fetch_if_id_if.sv
// Instruction-memory port between the fetch stage and the memory/cache.
// The fetch stage drives the request and the memory answers with data/done.
interface fetch_if_id_if;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        imem_done;

    modport master (
        output imem_addr,
        output imem_rd,
        input  imem_data,
        input  imem_done
    );

    modport slave (
        input  imem_addr,
        input  imem_rd,
        output imem_data,
        output imem_done
    );
endinterface

// File: rtl/fetch_if_id.sv
// Instruction-fetch stage and IF/ID pipeline register for the 16-bit core.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FETCH    | request outstanding at pc; accept returned word into IF/ID
// HOLD     | word returned during a decode stall; buffered until stall drops
// DISCARD  | redirect arrived mid-request; wait for done, drop the data
// HALTED   | HALT reached IF/ID; fetch frozen until a redirect
//
// IF/ID is overwritten by a bubble when decode is not stalled and nothing
// new is loaded, so decode never consumes the same word twice. A flush only
// clears IF/ID; the fetch side (pc, state, buffered word) carries on.
module fetch_if_id (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_sel,
    input  logic [15:0]           pc_jump_out,
    input  logic                  flush,
    input  logic                  stall_id,
    fetch_if_id_if.master         imem,
    output logic [15:0]           instr_IF_ID,
    output logic [15:0]           pc_add2_IF_ID,
    output logic                  valid_IF_ID,
    output logic                  halted
);

    localparam logic [15:0] NOP = 16'h0800;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic [15:0] r_redirect_pc;
    logic [15:0] w_redirect_nxt;
    logic [15:0] r_hold_instr;
    logic [15:0] w_hold_instr_nxt;
    logic [15:0] r_hold_pc2;
    logic [15:0] w_hold_pc2_nxt;
    logic [15:0] r_instr;
    logic [15:0] r_pc2;
    logic        r_valid;

    logic        w_rd;
    logic        w_load;
    logic [15:0] w_load_instr;
    logic [15:0] w_load_pc2;
    logic [15:0] w_pc_add2;
    logic        w_data_halt;
    logic        w_hold_halt;

    assign w_pc_add2   = r_pc + 16'd2;
    assign w_data_halt = (imem.imem_data[15:11] == 5'b00000);
    assign w_hold_halt = (r_hold_instr[15:11] == 5'b00000);

    // Next-state, next-pc, buffer and IF/ID load decisions.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_redirect_nxt   = r_redirect_pc;
        w_hold_instr_nxt = r_hold_instr;
        w_hold_pc2_nxt   = r_hold_pc2;
        w_rd             = 1'b0;
        w_load           = 1'b0;
        w_load_instr     = r_hold_instr;
        w_load_pc2       = r_hold_pc2;

        case (r_state)
            S_FETCH: begin
                w_rd = 1'b1;
                if (pc_sel) begin
                    if (imem.imem_done) begin
                        w_pc_nxt = pc_jump_out;
                    end else begin
                        w_redirect_nxt = pc_jump_out;
                        w_state_nxt    = S_DISCARD;
                    end
                end else if (imem.imem_done) begin
                    if (stall_id) begin
                        w_hold_instr_nxt = imem.imem_data;
                        w_hold_pc2_nxt   = w_pc_add2;
                        w_state_nxt      = S_HOLD;
                    end else begin
                        w_load       = 1'b1;
                        w_load_instr = imem.imem_data;
                        w_load_pc2   = w_pc_add2;
                        if (w_data_halt) begin
                            w_state_nxt = S_HALTED;
                        end
                    end
                    // HALT leaves pc parked on itself.
                    if (!w_data_halt) begin
                        w_pc_nxt = w_pc_add2;
                    end
                end
            end
            S_HOLD: begin
                if (pc_sel) begin
                    w_pc_nxt    = pc_jump_out;
                    w_state_nxt = S_FETCH;
                end else if (!stall_id) begin
                    w_load      = 1'b1;
                    w_state_nxt = w_hold_halt ? S_HALTED : S_FETCH;
                end
            end
            S_DISCARD: begin
                w_rd = 1'b1;
                if (pc_sel) begin
                    w_redirect_nxt = pc_jump_out;
                    if (imem.imem_done) begin
                        w_pc_nxt    = pc_jump_out;
                        w_state_nxt = S_FETCH;
                    end
                end else if (imem.imem_done) begin
                    w_pc_nxt    = r_redirect_pc;
                    w_state_nxt = S_FETCH;
                end
            end
            S_HALTED: begin
                if (pc_sel) begin
                    w_pc_nxt    = pc_jump_out;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // Fetch-side registers: state, pc, pending redirect target, stall buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_pc          <= 16'h0000;
            r_redirect_pc <= 16'h0000;
            r_hold_instr  <= NOP;
            r_hold_pc2    <= 16'h0000;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_redirect_pc <= w_redirect_nxt;
            r_hold_instr  <= w_hold_instr_nxt;
            r_hold_pc2    <= w_hold_pc2_nxt;
        end
    end

    // IF/ID register: flush beats stall, stall freezes, otherwise load or bubble.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_instr <= NOP;
            r_pc2   <= 16'h0000;
            r_valid <= 1'b0;
        end else if (!stall_id) begin
            if (w_load) begin
                r_instr <= w_load_instr;
                r_pc2   <= w_load_pc2;
                r_valid <= 1'b1;
            end else begin
                r_instr <= NOP;
                r_pc2   <= 16'h0000;
                r_valid <= 1'b0;
            end
        end
    end

    // A request in flight is abandoned the moment reset is seen.
    assign imem.imem_rd   = w_rd & ~rst;
    assign imem.imem_addr = r_pc;

    assign instr_IF_ID    = r_instr;
    assign pc_add2_IF_ID  = r_pc2;
    assign valid_IF_ID    = r_valid;
    assign halted         = (r_state == S_HALTED);

endmodule

// File: tb/tb_fetch_if_id.sv
// Bench for fetch_if_id: directed vector table, hand sequences for stalls,
// delayed redirects and flush, then random traffic against a flag-based model.
module tb_fetch_if_id;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_sel;
    logic [15:0] pc_jump_out;
    logic        flush;
    logic        stall_id;
    logic [15:0] instr_IF_ID;
    logic [15:0] pc_add2_IF_ID;
    logic        valid_IF_ID;
    logic        halted;

    int total = 0;
    int bad   = 0;

    fetch_if_id_if bus ();

    fetch_if_id dut (
        .clk           (clk),
        .rst           (rst),
        .pc_sel        (pc_sel),
        .pc_jump_out   (pc_jump_out),
        .flush         (flush),
        .stall_id      (stall_id),
        .imem          (bus),
        .instr_IF_ID   (instr_IF_ID),
        .pc_add2_IF_ID (pc_add2_IF_ID),
        .valid_IF_ID   (valid_IF_ID),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        psel;
        logic [15:0] jump;
        logic        fl;
        logic        st;
        logic        dn;
        logic [15:0] dat;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        valid;
        logic        hlt;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic ps, input logic [15:0] j, input logic fl,
                          input logic st, input logic dn, input logic [15:0] d);
        pc_sel        = ps;
        pc_jump_out   = j;
        flush         = fl;
        stall_id      = st;
        bus.imem_done = dn;
        bus.imem_data = d;
    endtask

    // Move to the next cycle's low phase, apply inputs, settle.
    task automatic step(input logic ps, input logic [15:0] j, input logic fl,
                        input logic st, input logic dn, input logic [15:0] d);
        @(negedge clk);
        set_in(ps, j, fl, st, dn, d);
        #1;
    endtask

    // Reset with a completing request on the bus: it must not be requested.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_in(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h4444);
        #1;
        chk("rst_rd_low", bus.imem_rd, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        #1;
        chk("rst_instr", instr_IF_ID, 16'h0800);
        chk("rst_pc2", pc_add2_IF_ID, 16'h0000);
        chk("rst_valid", valid_IF_ID, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_addr", bus.imem_addr, 16'h0000);
        chk("rst_rd", bus.imem_rd, 1'b1);
    endtask

    function automatic logic [15:0] memword(input logic [15:0] a);
        logic [15:0] t;
        t = (a * 16'h9E37) ^ 16'h5A5A;
        return t;
    endfunction

    // Behavioural model state
    logic [15:0] m_pc, m_tgt, m_bi, m_bp, e_instr, e_pc2;
    logic        m_sq, m_buf, m_halt, e_valid;

    initial begin
        logic        ps, fl, st, dn, e_rd, acc, ld;
        logic [15:0] j, d, ldi, ldp;

        rst = 1'b1;
        set_in(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);

        //            psel jump     fl st dn dat       rd addr      instr     pc2       v  h
        vecs[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h4001, 1'b1, 16'h0000, 16'h4001, 16'h0002, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h4002, 1'b1, 16'h0002, 16'h4002, 16'h0004, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h4003, 1'b1, 16'h0004, 16'h4003, 16'h0006, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 16'h0010, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h0006, 16'h0800, 16'h0000, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0010, 16'h0000, 16'h0012, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h4777, 1'b0, 16'h0010, 16'h0800, 16'h0000, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0010, 16'h0800, 16'h0000, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h4100, 1'b1, 16'h0100, 16'h4100, 16'h0102, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b1, 16'h5555, 1'b1, 16'h0102, 16'h0800, 16'h0000, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h4200, 1'b1, 16'hFFFE, 16'h4200, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h4201, 1'b1, 16'h0000, 16'h4201, 16'h0002, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0800, 16'h0000, 1'b0, 1'b0};

        do_reset();

        // Directed vectors: request checked before the edge, IF/ID after.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].psel, vecs[i].jump, vecs[i].fl, vecs[i].st, vecs[i].dn, vecs[i].dat);
            chk("vec_rd", bus.imem_rd, vecs[i].rd);
            chk("vec_addr", bus.imem_addr, vecs[i].addr);
            @(posedge clk);
            #1;
            chk("vec_instr", instr_IF_ID, vecs[i].instr);
            chk("vec_pc2", pc_add2_IF_ID, vecs[i].pc2);
            chk("vec_valid", valid_IF_ID, vecs[i].valid);
            chk("vec_halted", halted, vecs[i].hlt);
        end

        // Redirect while a slow request is outstanding at address 0.
        do_reset();
        chk("dly_addr0", bus.imem_addr, 16'h0000);
        step(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("dly_addr1", bus.imem_addr, 16'h0000);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("dly_addr2", bus.imem_addr, 16'h0000);
        chk("dly_rd2", bus.imem_rd, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h4ABC);
        chk("dly_addr3", bus.imem_addr, 16'h0000);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("dly_target", bus.imem_addr, 16'h0040);
        chk("dly_target_rd", bus.imem_rd, 1'b1);
        chk("dly_not_loaded", valid_IF_ID, 1'b0);
        chk("dly_instr", instr_IF_ID, 16'h0800);

        // Four-cycle decode stall while the next word returns.
        do_reset();
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h4001);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h4002);
        chk("stl_addr", bus.imem_addr, 16'h0002);
        chk("stl_instr0", instr_IF_ID, 16'h4001);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
            chk("stl_rd", bus.imem_rd, 1'b0);
            chk("stl_instr", instr_IF_ID, 16'h4001);
            chk("stl_pc2", pc_add2_IF_ID, 16'h0002);
            chk("stl_valid", valid_IF_ID, 1'b1);
        end
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("stl_drop_rd", bus.imem_rd, 1'b0);
        chk("stl_drop_instr", instr_IF_ID, 16'h4001);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h4003);
        chk("stl_buf_instr", instr_IF_ID, 16'h4002);
        chk("stl_buf_pc2", pc_add2_IF_ID, 16'h0004);
        chk("stl_buf_valid", valid_IF_ID, 1'b1);
        chk("stl_next_addr", bus.imem_addr, 16'h0004);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("stl_next_instr", instr_IF_ID, 16'h4003);
        chk("stl_next_pc2", pc_add2_IF_ID, 16'h0006);

        // Flush during a stall clears IF/ID but the buffered word survives.
        do_reset();
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h4001);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h4002);
        step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
        chk("fls_instr", instr_IF_ID, 16'h0800);
        chk("fls_valid", valid_IF_ID, 1'b0);
        chk("fls_pc2", pc_add2_IF_ID, 16'h0000);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("fls_buf_instr", instr_IF_ID, 16'h4002);
        chk("fls_buf_valid", valid_IF_ID, 1'b1);

        // Random traffic against the model.
        do_reset();
        m_pc = 16'h0; m_tgt = 16'h0; m_bi = 16'h0; m_bp = 16'h0;
        m_sq = 1'b0; m_buf = 1'b0; m_halt = 1'b0;
        e_instr = 16'h0800; e_pc2 = 16'h0; e_valid = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            e_rd = !(m_buf || m_halt);
            ps = ($urandom_range(0, 99) < 12);
            j  = 16'($urandom);
            fl = ps && ($urandom_range(0, 1) == 1);
            st = ($urandom_range(0, 99) < 25);
            dn = e_rd && ($urandom_range(0, 99) < 60);
            d  = e_rd ? memword(m_pc) : 16'($urandom);
            step(ps, j, fl, st, dn, d);
            chk("rnd_rd", bus.imem_rd, e_rd);
            chk("rnd_addr", bus.imem_addr, m_pc);
            chk("rnd_instr", instr_IF_ID, e_instr);
            chk("rnd_pc2", pc_add2_IF_ID, e_pc2);
            chk("rnd_valid", valid_IF_ID, e_valid);
            chk("rnd_halted", halted, m_halt);

            acc = e_rd && dn;
            ld  = 1'b0; ldi = 16'h0; ldp = 16'h0;
            if (ps) begin
                if (e_rd && !acc) begin
                    m_sq = 1'b1; m_tgt = j;
                end else begin
                    m_pc = j; m_sq = 1'b0; m_buf = 1'b0; m_halt = 1'b0;
                end
            end else if (m_sq) begin
                if (acc) begin
                    m_pc = m_tgt; m_sq = 1'b0;
                end
            end else if (m_buf) begin
                if (!st) begin
                    ld = 1'b1; ldi = m_bi; ldp = m_bp; m_buf = 1'b0;
                    m_halt = (m_bi[15:11] == 5'b00000);
                end
            end else if (!m_halt && acc) begin
                if (st) begin
                    m_buf = 1'b1; m_bi = d; m_bp = m_pc + 16'd2;
                end else begin
                    ld = 1'b1; ldi = d; ldp = m_pc + 16'd2;
                    m_halt = (d[15:11] == 5'b00000);
                end
                if (d[15:11] != 5'b00000) m_pc = m_pc + 16'd2;
            end
            if (fl) begin
                e_instr = 16'h0800; e_pc2 = 16'h0; e_valid = 1'b0;
            end else if (!st) begin
                if (ld) begin
                    e_instr = ldi; e_pc2 = ldp; e_valid = 1'b1;
                end else begin
                    e_instr = 16'h0800; e_pc2 = 16'h0; e_valid = 1'b0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_if_id.md
# fetch_if_id

Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined core. Holds the PC, issues requests to the instruction-memory/cache port with a rd/done handshake, and loads the fetched word and PC+2 into the IF/ID register. Consumes the decode-stage redirect (`pc_sel`, `pc_jump_out`) and `flush`, and produces `instr_IF_ID`/`pc_add2_IF_ID` for decode. Squashes wrong-path fetches, buffers a returned word during decode stalls, and freezes on HALT.

## Interface
- No parameters.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc_sel` in 1: redirect request from decode.
- `pc_jump_out` in 16: redirect target, valid when `pc_sel`=1.
- `flush` in 1: squash IF/ID contents.
- `stall_id` in 1: decode hazard stall; hold IF/ID and PC.
- `imem_addr` out 16: fetch address, held stable while a request is outstanding.
- `imem_rd` out 1: fetch request.
- `imem_data` in 16: fetched word, valid only in the cycle `imem_done`=1.
- `imem_done` in 1: request complete; may arrive in the same cycle as `imem_rd`.
- `instr_IF_ID` out 16: registered instruction (NOP = 16'h0800).
- `pc_add2_IF_ID` out 16: registered PC+2 of that instruction.
- `valid_IF_ID` out 1: IF/ID holds a real instruction.
- `halted` out 1: fetch frozen on HALT.

## Operation
- Registers: `pc`, `redirect_pc`, `hold_instr`, `hold_pc2`, IF/ID (`instr`, `pc2`, `valid`), and a 2-bit state.
- States: FETCH, HOLD, DISCARD, HALTED.
- Reset values: `pc`=0; state=FETCH; `instr_IF_ID`=16'h0800; `pc_add2_IF_ID`=0; `valid_IF_ID`=0; `halted`=0. `imem_rd`=0 while `rst`=1.
- FETCH: `imem_rd`=1, `imem_addr`=`pc`.
  - `imem_done` & !`stall_id`: IF/ID <= {`imem_data`, `pc`+2, valid=1}; `pc` <= `pc`+2.
  - `imem_done` & `stall_id`: `hold_*` <= {`imem_data`, `pc`+2}; `pc` <= `pc`+2; go to HOLD.
  - If the accepted word has opcode `instr[15:11]`=5'b00000 (HALT): load it to IF/ID (or hold) as usual, but do not advance `pc`; go to HALTED once it is in IF/ID.
- HOLD: `imem_rd`=0. When `stall_id` drops, IF/ID <= `hold_*`, valid=1; return to FETCH, or go to HALTED if the held word is HALT.
- DISCARD: `imem_rd`=1, `imem_addr` = old `pc` (unchanged). On `imem_done`: drop the data, `pc` <= `redirect_pc`, go to FETCH.
- HALTED: `imem_rd`=0; `halted`=1; `pc` frozen. Exit only on `pc_sel`.
- Redirect (`pc_sel`=1), all states; overrides `stall_id`:
  - FETCH with `imem_done`: drop the data; `pc` <= `pc_jump_out`; stay in FETCH.
  - FETCH without `imem_done`: `redirect_pc` <= `pc_jump_out`; go to DISCARD.
  - DISCARD: `redirect_pc` <= `pc_jump_out`; the latest target wins. If `imem_done` arrives in the same cycle, go to FETCH at `pc_jump_out`.
  - HOLD or HALTED: discard the held word; `pc` <= `pc_jump_out`; go to FETCH; `halted` <= 0.
- `flush`=1: IF/ID <= {16'h0800, 0, valid=0}. Overrides both the load path and `stall_id`. Does not change `pc` or state unless `pc_sel` is also asserted.
- PC arithmetic is 16-bit modulo: 16'hFFFE+2 = 16'h0000. Bit 0 of `pc_jump_out` is passed through unmodified.

## Timing
- Single-cycle memory (`imem_done` in the same cycle as `imem_rd`): one instruction per cycle. The word fetched at address A appears on `instr_IF_ID` in the cycle after the request.
- Redirect latency: `pc_sel` in cycle N → `imem_addr`=target in N+1 (from FETCH/HOLD/HALTED). From DISCARD, the target is issued the cycle after the outstanding `imem_done`.
- While `stall_id`=1 and no flush: IF/ID outputs are unchanged cycle to cycle.
- `rst` asserted mid-request: the outstanding request is abandoned. `imem_rd`=0 for the reset cycle, and fetch restarts at 0.

## Test plan
- Reset, then single-cycle memory returns 16'h4001, 16'h4002, 16'h4003 → IF/ID shows these with `pc_add2` 2, 4, 6 on consecutive cycles; `valid`=1.
- `imem_done` delayed 3 cycles at addr 0 while `pc_sel`=1 with target 16'h0040 in cycle 1 → `imem_addr` stays 0 until done; that word is never loaded; the next request is at 16'h0040.
- `stall_id`=1 for 4 cycles while a word returns → IF/ID unchanged throughout; the buffered word appears in the cycle after the stall drops; no word is lost or duplicated.
- `flush` together with `stall_id` → `instr_IF_ID`=16'h0800, `valid`=0.
- HALT (16'h0000) fetched at 16'h0010 → IF/ID shows 16'h0000 with `pc_add2`=16'h0012; `halted`=1; `imem_rd`=0. Later `pc_sel` to 16'h0100 → fetch resumes at 16'h0100; `halted`=0.
- PC wrap: redirect to 16'hFFFE → next fetch address is 16'h0000; `pc_add2_IF_ID`=16'h0000.
